fwd_ctrl: RTL and testbench

Pipeline forwarding and load-use hazard controller for the pipelined core. It tracks the destination registers of instructions in the EX, MEM and WB stages in internal shadow registers. It drives the 2-bit select inputs of the two ALU-operand 3-to-1 muxes: 00 selects the register file, 01 the MEM-stage ALU result, 10 the WB-stage write-back data. It also raises a one-cycle stall on load-use hazards and counts stall cycles.

---
 rtl/fwd_ctrl_if.sv | 29 ++
 rtl/fwd_ctrl.sv | 84 ++++++++
 tb/tb_fwd_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_ctrl_if.sv
// ID-stage instruction fields into the forwarding/hazard controller, mux selects and stall out.
// id_valid qualifies the ID fields; stall=1 means the ID instruction was not accepted and must be re-presented.
interface fwd_ctrl_if #(
  parameter int AW = 5,
  parameter int CW = 16
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rt;
  logic [AW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_memread;
  logic          flush;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          stall;
  logic [CW-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread, flush,
    input  fwd_a, fwd_b, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread, flush,
    output fwd_a, fwd_b, stall, stall_count
  );
endinterface

// File: rtl/fwd_ctrl.sv
// Forwarding-select and load-use stall controller driven by a shadow copy of the EX/MEM/WB
// destination registers; also keeps a saturating count of stall cycles.
module fwd_ctrl #(
  parameter int AW = 5,
  parameter int CW = 16
) (
  input logic       clk,
  input logic       rst,
  fwd_ctrl_if.slave bus
);

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic          we;
    logic          mr;
  } ex_t;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          we;
  } wr_t;

  ex_t           ex_q, ex_d;
  wr_t           mem_q, mem_d;
  wr_t           wb_q, wb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;

  // r0 is hardwired zero, so a write to it is never a producer.
  function automatic logic hits(input wr_t w, input logic [AW-1:0] src);
    return w.we && (w.rd != '0) && (w.rd == src);
  endfunction

  // Newest producer (MEM) wins over the older one (WB).
  function automatic logic [1:0] sel(input wr_t m, input wr_t w, input logic [AW-1:0] src);
    logic [1:0] s;
    s = 2'b00;
    if (hits(m, src))      s = 2'b01;
    else if (hits(w, src)) s = 2'b10;
    return s;
  endfunction

  always_comb begin
    stall = 1'b0;
    if (bus.id_valid && !bus.flush && ex_q.mr && ex_q.we && (ex_q.rd != '0))
      stall = (ex_q.rd == bus.id_rs) || (bus.id_uses_rt && (ex_q.rd == bus.id_rt));

    ex_d = '0;
    if (bus.id_valid && !bus.flush && !stall)
      ex_d = '{rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
               we: bus.id_regwrite, mr: bus.id_memread};

    mem_d = '{rd: ex_q.rd, we: ex_q.we};
    wb_d  = mem_q;

    cnt_d = cnt_q;
    if (stall && (cnt_q != {CW{1'b1}}))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    bus.fwd_a       = sel(mem_q, wb_q, ex_q.rs);
    bus.fwd_b       = sel(mem_q, wb_q, ex_q.rt);
    bus.stall       = stall;
    bus.stall_count = cnt_q;
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed and randomized checks of fwd_ctrl against an instruction-history reference model.
module tb_fwd_ctrl;

  localparam int AW = 5;
  localparam int CW = 2;

  logic clk;
  logic rst;

  fwd_ctrl_if #(.AW(AW), .CW(CW)) bus();

  fwd_ctrl #(.AW(AW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic          we;
    logic          mr;
    logic          uses_rt;
  } ins_t;

  int   tests = 0;
  int   fails = 0;
  ins_t hist[$];      // hist[0] = instruction now in EX, [1] in MEM, [2] in WB
  int   model_stalls;
  logic last_stall;

  function automatic ins_t mk(input int rs, input int rt, input int rd,
                              input bit we, input bit mr, input bit uses_rt);
    ins_t i;
    i.valid = 1'b1; i.rs = AW'(rs); i.rt = AW'(rt); i.rd = AW'(rd);
    i.we = we; i.mr = mr; i.uses_rt = uses_rt;
    return i;
  endfunction

  function automatic ins_t bubble();
    ins_t i;
    i.valid = 1'b0; i.rs = '0; i.rt = '0; i.rd = '0;
    i.we = 1'b0; i.mr = 1'b0; i.uses_rt = 1'b0;
    return i;
  endfunction

  function automatic int exp_count();
    return (model_stalls > 3) ? 3 : model_stalls;
  endfunction

  // A value is available for forwarding only from a real writer of a non-zero register.
  function automatic bit produces(input ins_t p, input logic [AW-1:0] r);
    return p.valid && p.we && (p.rd != 0) && (p.rd == r);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] r);
    if (produces(hist[1], r)) return 2'b01;
    if (produces(hist[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_stall(input ins_t i, input bit fl);
    ins_t ld;
    ld = hist[0];
    if (!i.valid || fl || !ld.valid || !ld.mr || !ld.we || ld.rd == 0) return 1'b0;
    return (ld.rd == i.rs) || (i.uses_rt && ld.rd == i.rt);
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(bubble());
    model_stalls = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present ID inputs at the negedge, check stall, clock, check selects.
  task automatic step(input ins_t i, input bit fl);
    bit   s;
    ins_t ent;
    bus.id_valid    = i.valid;
    bus.id_rs       = i.rs;
    bus.id_rt       = i.rt;
    bus.id_rd       = i.rd;
    bus.id_regwrite = i.we;
    bus.id_memread  = i.mr;
    bus.id_uses_rt  = i.uses_rt;
    bus.flush       = fl;
    #1;
    s = exp_stall(i, fl);
    last_stall = bus.stall;
    chk("stall", {15'd0, bus.stall}, {15'd0, s});
    @(posedge clk);
    if (s) model_stalls++;
    ent = (i.valid && !fl && !s) ? i : bubble();
    hist.push_front(ent);
    hist.pop_back();
    #1;
    chk("fwd_a", {14'd0, bus.fwd_a}, {14'd0, exp_fwd(hist[0].rs)});
    chk("fwd_b", {14'd0, bus.fwd_b}, {14'd0, exp_fwd(hist[0].rt)});
    chk("stall_count", {14'd0, bus.stall_count}, 16'(exp_count()));
    @(negedge clk);
  endtask

  task automatic load_use_pair();
    step(mk(1, 0, 2, 1, 1, 0), 1'b0);
    step(mk(2, 1, 4, 1, 0, 1), 1'b0);
    step(mk(2, 1, 4, 1, 0, 1), 1'b0);
  endtask

  initial begin
    ins_t cur;
    bit   fl;
    rst = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_regwrite = 1'b0; bus.id_memread = 1'b0; bus.id_uses_rt = 1'b0; bus.flush = 1'b0;
    model_reset();

    // Held in reset with random ID activity.
    repeat (3) begin
      @(negedge clk);
      bus.id_valid = 1'b1; bus.id_rs = AW'($urandom_range(0, 31));
      bus.id_rt = AW'($urandom_range(0, 31)); bus.id_rd = AW'($urandom_range(0, 31));
      bus.id_regwrite = 1'b1; bus.id_memread = 1'($urandom_range(0, 1));
      bus.id_uses_rt = 1'b1; bus.flush = 1'b0;
      #1;
      chk("rst_fwd_a", {14'd0, bus.fwd_a}, 16'd0);
      chk("rst_fwd_b", {14'd0, bus.fwd_b}, 16'd0);
      chk("rst_stall", {15'd0, bus.stall}, 16'd0);
      chk("rst_count", {14'd0, bus.stall_count}, 16'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    step(mk(7, 8, 9, 1, 0, 1), 1'b0);
    chk("first_fwd", {12'd0, bus.fwd_a, bus.fwd_b}, 16'd0);

    // Distance 1 and distance 2.
    step(mk(1, 2, 3, 1, 0, 1), 1'b0);
    step(mk(3, 4, 5, 1, 0, 1), 1'b0);
    chk("dist1_fwd_a", {14'd0, bus.fwd_a}, 16'd1);
    step(mk(1, 2, 3, 1, 0, 1), 1'b0);
    step(bubble(), 1'b0);
    step(mk(4, 3, 5, 1, 0, 1), 1'b0);
    chk("dist2_fwd_b", {14'd0, bus.fwd_b}, 16'd2);

    // Priority and r0.
    step(mk(1, 2, 3, 1, 0, 1), 1'b0);
    step(mk(1, 2, 3, 1, 0, 1), 1'b0);
    step(mk(3, 3, 6, 1, 0, 1), 1'b0);
    chk("prio_fwd", {12'd0, bus.fwd_a, bus.fwd_b}, 16'b0101);
    step(mk(1, 2, 0, 1, 0, 1), 1'b0);
    step(mk(0, 0, 6, 1, 0, 1), 1'b0);
    chk("r0_fwd", {12'd0, bus.fwd_a, bus.fwd_b}, 16'd0);

    // Load-use, then the same with rt not read.
    step(mk(1, 0, 2, 1, 1, 0), 1'b0);
    step(mk(2, 1, 4, 1, 0, 1), 1'b0);
    chk("lu_stall", {15'd0, last_stall}, 16'd1);
    step(mk(2, 1, 4, 1, 0, 1), 1'b0);
    chk("lu_stall_once", {15'd0, last_stall}, 16'd0);
    chk("lu_fwd_a", {14'd0, bus.fwd_a}, 16'd2);
    chk("lu_count", {14'd0, bus.stall_count}, 16'd1);
    step(mk(1, 0, 2, 1, 1, 0), 1'b0);
    step(mk(1, 2, 4, 1, 0, 0), 1'b0);
    chk("lu_no_rt", {15'd0, last_stall}, 16'd0);

    // Flush against a pending load-use; the squashed writer of r7 must not forward.
    step(mk(1, 0, 2, 1, 1, 0), 1'b0);
    step(mk(2, 1, 7, 1, 0, 1), 1'b1);
    chk("flush_stall", {15'd0, last_stall}, 16'd0);
    step(mk(7, 7, 8, 1, 0, 1), 1'b0);
    chk("flush_fwd", {12'd0, bus.fwd_a, bus.fwd_b}, 16'd0);
    chk("flush_count", {14'd0, bus.stall_count}, 16'd1);

    // Saturation of the 2-bit counter.
    repeat (4) load_use_pair();
    chk("sat_count", {14'd0, bus.stall_count}, 16'd3);
    load_use_pair();
    chk("sat_hold", {14'd0, bus.stall_count}, 16'd3);

    // Randomized traffic; a stalled instruction is re-presented next cycle.
    cur = bubble();
    for (int n = 0; n < 400; n++) begin
      if (!(last_stall === 1'b1)) begin
        cur = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
        cur.valid = ($urandom_range(0, 7) != 0);
      end
      fl = ($urandom_range(0, 7) == 0);
      step(cur, fl);
    end

    // Mid-stream asynchronous reset with live producers.
    step(mk(1, 2, 3, 1, 0, 1), 1'b0);
    step(mk(3, 3, 3, 1, 1, 1), 1'b0);
    bus.id_valid = 1'b1; bus.id_rs = 5'd3; bus.id_rt = 5'd3; bus.flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_fwd", {12'd0, bus.fwd_a, bus.fwd_b}, 16'd0);
    chk("mid_rst_stall", {15'd0, bus.stall}, 16'd0);
    chk("mid_rst_count", {14'd0, bus.stall_count}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    step(mk(3, 3, 4, 1, 0, 1), 1'b0);
    chk("post_rst_fwd", {12'd0, bus.fwd_a, bus.fwd_b}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
